// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_arb_pkg                                                         |
// | Shared types and constants for the UART transmit arbiter.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PASS = 2'd2
   } arb_state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

   // Grant index width; never narrower than one bit.
   function automatic int sel_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter_if                                                   |
// | Requester streams, transmitter stream and grant status bundle.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface uart_tx_arbiter_if
   import uart_arb_pkg::*;
#(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8
);
   localparam int SEL_W = sel_width(PORTS);

   logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata;
   logic [PORTS-1:0]            s_axis_tvalid;
   logic [PORTS-1:0]            s_axis_tlast;
   logic [PORTS-1:0]            s_axis_tready;
   logic [DATA_WIDTH-1:0]       m_axis_tdata;
   logic                        m_axis_tvalid;
   logic                        m_axis_tready;
   logic                        tx_busy;
   logic                        grant_valid;
   logic [SEL_W-1:0]            grant_index;

   // Environment side: requesters, transmitter and status consumer.
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, tx_busy,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_index
   );

   // Arbiter side.
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, tx_busy,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, grant_valid, grant_index
   );

endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_select                                                            |
// | Round-robin priority encoder: first request above ptr, wrapping.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_select #(
   parameter int PORTS = 4,
   parameter int SEL_W = 2
) (
   input  logic [PORTS-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] sel,
   output logic             any
);

   int               idx;
   logic [SEL_W-1:0] idx_s;

   always_comb begin
      sel   = '0;
      any   = 1'b0;
      idx   = 0;
      idx_s = '0;
      for (int k = 1; k <= PORTS; k++) begin
         idx   = (int'(ptr) + k) % PORTS;
         idx_s = SEL_W'(idx);
         if (!any && req[idx_s]) begin
            any = 1'b1;
            sel = idx_s;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_arbiter                                                      |
// | Packet-locked round-robin share of one AXI4-Stream UART transmitter. |
// | Optional source-ID header byte: define UART_ARB_SRC_HDR_EN.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int PORTS      = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   uart_tx_arbiter_if.slave  bus
);

   localparam int SEL_W = sel_width(PORTS);

   arb_state_t            state;
   arb_state_t            state_next;
   logic [SEL_W-1:0]      grant_idx;
   logic [SEL_W-1:0]      grant_idx_next;
   logic                  grant_vld;
   logic                  grant_vld_next;
   logic [SEL_W-1:0]      ptr;
   logic [SEL_W-1:0]      ptr_next;

   logic [SEL_W-1:0]      rr_sel;
   logic                  rr_any;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_valid;
   logic                  sel_last;
   logic                  unused_tx_busy;

   rr_select #(
      .PORTS (PORTS),
      .SEL_W (SEL_W)
   ) u_rr_select (
      .req (bus.s_axis_tvalid),
      .ptr (ptr),
      .sel (rr_sel),
      .any (rr_any)
   );

   assign sel_data       = bus.s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_valid      = bus.s_axis_tvalid[grant_idx];
   assign sel_last       = bus.s_axis_tlast[grant_idx];
   assign unused_tx_busy = bus.tx_busy;

`ifdef UART_ARB_SRC_HDR_EN
   logic [DATA_WIDTH-1:0] hdr_byte;

   // Tag in the top nibble, granted port number in the low bits.
   always_comb begin
      hdr_byte                     = '0;
      hdr_byte[DATA_WIDTH-1 -: 4]  = HDR_TAG;
      hdr_byte[SEL_W-1:0]          = grant_idx;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_idx <= '0;
         grant_vld <= 1'b0;
         ptr       <= SEL_W'(PORTS - 1);
      end else begin
         state     <= state_next;
         grant_idx <= grant_idx_next;
         grant_vld <= grant_vld_next;
         ptr       <= ptr_next;
      end
   end

   always_comb begin
      state_next         = state;
      grant_idx_next     = grant_idx;
      grant_vld_next     = grant_vld;
      ptr_next           = ptr;
      bus.m_axis_tdata   = '0;
      bus.m_axis_tvalid  = 1'b0;
      bus.s_axis_tready  = '0;

      case (state)
         IDLE: begin
            if (rr_any) begin
               grant_idx_next = rr_sel;
               grant_vld_next = 1'b1;
`ifdef UART_ARB_SRC_HDR_EN
               state_next     = HDR;
`else
               state_next     = PASS;
`endif
            end
         end
`ifdef UART_ARB_SRC_HDR_EN
         HDR: begin
            bus.m_axis_tvalid = 1'b1;
            bus.m_axis_tdata  = hdr_byte;
            if (bus.m_axis_tready) begin
               state_next = PASS;
            end
         end
`endif
         PASS: begin
            bus.m_axis_tdata             = sel_data;
            bus.m_axis_tvalid            = sel_valid;
            bus.s_axis_tready[grant_idx] = bus.m_axis_tready;
            // Grant is released only by the tlast handshake; stalls keep it.
            if (sel_valid && bus.m_axis_tready && sel_last) begin
               ptr_next       = grant_idx;
               grant_vld_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.grant_valid = grant_vld;
   assign bus.grant_index = grant_idx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_tx_arbiter                                                   |
// | Directed scoreboard bench for uart_tx_arbiter.                       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_tx_arbiter;

   localparam int PORTS = 4;
   localparam int DW    = 8;
`ifdef UART_ARB_SRC_HDR_EN
   localparam bit HDR_EN = 1'b1;
`else
   localparam bit HDR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.PORTS(PORTS), .DATA_WIDTH(DW)) bus ();

   uart_tx_arbiter #(
      .PORTS      (PORTS),
      .DATA_WIDTH (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int idx;
      bit gap_chk;
   } gexp_t;

   logic [8:0]       src_mem [PORTS][32];
   int               src_rd  [PORTS];
   int               src_wr  [PORTS];
   logic [PORTS-1:0] gap;
   logic [PORTS-1:0] took;
   bit               gap_toggle;
   bit               rdy_toggle;

   gexp_t      exp_g[$];
   logic [7:0] exp_d[$];
   int vectors     = 0;
   int miscompares = 0;
   int out_count   = 0;
   int idle_cnt    = 1000;
   bit prev_gv     = 1'b0;
   bit hdr_pending = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Requester models: each port replays its own byte queue.
   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         bus.s_axis_tvalid[p]        = (src_rd[p] != src_wr[p]) && !gap[p];
         bus.s_axis_tdata[p*DW +: DW] = src_mem[p][src_rd[p][4:0]][7:0];
         bus.s_axis_tlast[p]         = src_mem[p][src_rd[p][4:0]][8];
      end
   end

   always begin
      @(negedge clk);
      took = bus.s_axis_tvalid & bus.s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < PORTS; p++) if (took[p]) src_rd[p]++;
      if (gap_toggle) gap[0] = ~gap[0];
      if (rdy_toggle) bus.m_axis_tready = ~bus.m_axis_tready;
   end

   // Output monitor: grants, ready routing and forwarded bytes.
   always @(negedge clk) begin
      if (rst) begin
         prev_gv     = 1'b0;
         hdr_pending = 1'b0;
         idle_cnt    = 1000;
      end else begin
         if (bus.grant_valid && !prev_gv) begin
            if (exp_g.size() == 0) begin
               chk("unexpected_grant_qsize", exp_g.size(), 1);
            end else begin
               gexp_t g;
               g = exp_g.pop_front();
               chk("grant_index", bus.grant_index, g.idx);
               if (g.gap_chk) chk("idle_cycles_between_grants", idle_cnt, 1);
            end
            hdr_pending = HDR_EN;
         end
         idle_cnt = bus.grant_valid ? 0 : idle_cnt + 1;
         prev_gv  = bus.grant_valid;

         for (int p = 0; p < PORTS; p++) begin
            chk($sformatf("s_tready[%0d]", p), bus.s_axis_tready[p],
                bus.grant_valid && (p == int'(bus.grant_index)) &&
                bus.m_axis_tready && !hdr_pending);
         end

         if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            if (exp_d.size() == 0) begin
               chk("unexpected_byte_qsize", exp_d.size(), 1);
            end else begin
               chk("m_tdata", bus.m_axis_tdata, exp_d.pop_front());
            end
            out_count++;
            hdr_pending = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int p, input logic [7:0] d, input logic l);
      src_mem[p][src_wr[p][4:0]] = {l, d};
      src_wr[p]++;
   endtask

   task automatic expect_pkt(input int p, input bit gap_chk);
      gexp_t g;
      g.idx     = p;
      g.gap_chk = gap_chk;
      exp_g.push_back(g);
      if (HDR_EN) exp_d.push_back(8'hA0 | 8'(p));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((exp_d.size() != 0 || exp_g.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      chk({tag, "_drain_left"}, exp_d.size() + exp_g.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_grant_valid"}, bus.grant_valid, 0);
      chk({tag, "_grant_index"}, bus.grant_index, 0);
      chk({tag, "_m_tvalid"}, bus.m_axis_tvalid, 0);
      chk({tag, "_s_tready"}, bus.s_axis_tready, 0);
   endtask

   initial begin
      int base;
      int n;
      rst               = 1'b1;
      bus.m_axis_tready = 1'b1;
      bus.tx_busy       = 1'b0;
      gap               = '0;
      gap_toggle        = 1'b0;
      rdy_toggle        = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
         src_rd[p] = 0;
         src_wr[p] = 0;
      end
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b0;
      tick();

      // Fairness: every port queues two single-byte packets.
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < PORTS; p++) begin
            load(p, 8'h40 + 8'(16*r + p), 1'b1);
            expect_pkt(p, !(r == 0 && p == 0));
            exp_d.push_back(8'h40 + 8'(16*r + p));
         end
      end
      wait_drain("rr", 400);

      // Single 3-byte packet from port 2 with one-cycle grant latency.
      load(2, 8'h11, 1'b0);
      load(2, 8'h22, 1'b0);
      load(2, 8'h33, 1'b1);
      expect_pkt(2, 1'b0);
      exp_d.push_back(8'h11);
      exp_d.push_back(8'h22);
      exp_d.push_back(8'h33);
      chk("p2_grant_valid_before", bus.grant_valid, 0);
      tick();
      chk("p2_grant_valid_lat1", bus.grant_valid, 1);
      chk("p2_grant_index_lat1", bus.grant_index, 2);
      wait_drain("single", 100);
      chk("p2_grant_valid_after", bus.grant_valid, 0);

      // Packet lock: port 0 stalls mid-packet while port 1 waits.
      for (int i = 0; i < 4; i++) load(0, 8'hA1 + 8'(i), (i == 3));
      load(1, 8'hB1, 1'b0);
      load(1, 8'hB2, 1'b1);
      expect_pkt(0, 1'b0);
      for (int i = 0; i < 4; i++) exp_d.push_back(8'hA1 + 8'(i));
      expect_pkt(1, 1'b1);
      exp_d.push_back(8'hB1);
      exp_d.push_back(8'hB2);
      tick();
      gap_toggle = 1'b1;
      wait_drain("lock", 200);
      gap_toggle = 1'b0;
      gap        = '0;

      // Backpressure: transmitter ready toggles every cycle.
      for (int i = 0; i < 5; i++) load(2, 8'hC1 + 8'(i), (i == 4));
      expect_pkt(2, 1'b0);
      for (int i = 0; i < 5; i++) exp_d.push_back(8'hC1 + 8'(i));
      bus.tx_busy = 1'b1;
      rdy_toggle  = 1'b1;
      wait_drain("bp", 200);
      rdy_toggle        = 1'b0;
      bus.m_axis_tready = 1'b1;
      bus.tx_busy       = 1'b0;
      tick();

      // Reset after two payload bytes of a four-byte packet.
      for (int i = 0; i < 4; i++) load(3, 8'hD1 + 8'(i), (i == 3));
      expect_pkt(3, 1'b0);
      for (int i = 0; i < 4; i++) exp_d.push_back(8'hD1 + 8'(i));
      base = out_count;
      n    = 0;
      while (out_count < base + 2 + int'(HDR_EN) && n < 50) begin
         tick();
         n++;
      end
      chk("rst_mid_bytes_seen", out_count - base, 2 + int'(HDR_EN));
      rst = 1'b1;
      tick();
      for (int p = 0; p < PORTS; p++) src_rd[p] = src_wr[p];
      exp_d.delete();
      exp_g.delete();
      check_reset_vals("rst_mid");
      rst = 1'b0;
      tick();
      load(3, 8'hE3, 1'b1);
      load(0, 8'hE0, 1'b1);
      expect_pkt(0, 1'b0);
      exp_d.push_back(8'hE0);
      expect_pkt(3, 1'b1);
      exp_d.push_back(8'hE3);
      wait_drain("post_rst", 100);

      // Single byte from port 1 (header-prefixed when enabled).
      load(1, 8'h55, 1'b1);
      expect_pkt(1, 1'b0);
      exp_d.push_back(8'h55);
      wait_drain("hdr", 100);

      repeat (3) tick();
      chk("final_grant_valid", bus.grant_valid, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
